store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer.sv | 135 +++++++++++++
 tb/tb_store_buffer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Store buffer: circular FIFO of pending stores draining one entry per cycle to data memory.
// Optional load forwarding from buffered stores when STORE_BUFFER_FWD_EN is defined.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 10
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [AW-1:0]            st_addr,
  input  logic [31:0]              st_data,
  input  logic [31:0]              st_pc,
  input  logic                     ld_valid,
  input  logic [AW-1:0]            ld_addr,
  output logic                     ld_hit,
  output logic [31:0]              ld_data,
  output logic                     ld_stall,
  output logic                     dm_memw,
  output logic [AW-1:0]            dm_add,
  output logic [31:0]              dm_wdata,
  output logic [31:0]              dm_pc,
  input  logic                     flush_req,
  output logic                     flush_done,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     dbg_state_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [PW:0]     count_q, count_d;
  logic            flush_done_q, flush_done_d;

  logic [AW-1:0]   addr_q [DEPTH];
  logic [31:0]     data_q [DEPTH];
  logic [31:0]     pc_q   [DEPTH];

  logic            push, pop;

  // Handshake: a store transfers on a rising edge when st_valid && st_ready;
  // st_ready never depends on st_valid, and the memory side accepts every cycle dm_memw is high.
  assign st_ready    = (count_q < CNT_FULL) && (state_q == RUN);
  assign push        = st_valid && st_ready;
  assign empty       = (count_q == '0);
  assign dm_memw     = !empty;
  assign pop         = dm_memw;
  assign count       = count_q;
  assign flush_done  = flush_done_q;
  assign dbg_state_o = (state_q == FLUSH);

  assign dm_add   = empty ? '0 : addr_q[head_q];
  assign dm_wdata = empty ? '0 : data_q[head_q];
  assign dm_pc    = empty ? '0 : pc_q[head_q];

  always_comb begin
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    state_d      = state_q;
    flush_done_d = 1'b0;
    if (push) tail_d = tail_q + 1'b1;
    if (pop)  head_d = head_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
    case (state_q)
      RUN: begin
        if (flush_req) state_d = FLUSH;
      end
      FLUSH: begin
        // Leaves on the edge that drains the last entry, or next edge if already empty.
        if (count_d == '0) begin
          state_d      = RUN;
          flush_done_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q      <= RUN;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      flush_done_q <= flush_done_d;
    end
  end

  // Payload is only meaningful under the occupancy count, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= st_addr;
      data_q[tail_q] <= st_data;
      pc_q[tail_q]   <= st_pc;
    end
  end

`ifdef STORE_BUFFER_FWD_EN
  logic [PW-1:0] fwd_idx;
  always_comb begin
    ld_hit  = 1'b0;
    ld_data = '0;
    fwd_idx = '0;
    // Walk oldest to youngest so the youngest matching store wins.
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = head_q + PW'(k);
      if (ld_valid && ((PW+1)'(k) < count_q) && (addr_q[fwd_idx] == ld_addr)) begin
        ld_hit  = 1'b1;
        ld_data = data_q[fwd_idx];
      end
    end
  end
  assign ld_stall = 1'b0;
`else
  logic unused_ld_addr;
  assign unused_ld_addr = ^ld_addr;
  assign ld_hit   = 1'b0;
  assign ld_data  = '0;
  assign ld_stall = ld_valid && !empty;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: cycle vector table plus flush and mid-operation reset sequences,
// with a write-order scoreboard on the data-memory port.
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 10;
  localparam int QW    = AW + 64;

`ifdef STORE_BUFFER_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk, clr;
  logic          st_valid, st_ready;
  logic [AW-1:0] st_addr;
  logic [31:0]   st_data, st_pc;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic          ld_hit, ld_stall;
  logic [31:0]   ld_data;
  logic          dm_memw;
  logic [AW-1:0] dm_add;
  logic [31:0]   dm_wdata, dm_pc;
  logic          flush_req, flush_done, empty;
  logic [2:0]    count;
  logic          dbg_state;

  int errors = 0;
  int checks = 0;
  logic [QW-1:0] exp_q[$];

  store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .clr(clr),
    .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_pc(st_pc),
    .ld_valid(ld_valid), .ld_addr(ld_addr),
    .ld_hit(ld_hit), .ld_data(ld_data), .ld_stall(ld_stall),
    .dm_memw(dm_memw), .dm_add(dm_add), .dm_wdata(dm_wdata), .dm_pc(dm_pc),
    .flush_req(flush_req), .flush_done(flush_done),
    .empty(empty), .count(count), .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pc_of(input logic [AW-1:0] a);
    return 32'hA000_0000 | {22'h0, a};
  endfunction

  // driver: inputs change #1 after the rising edge; accepted stores enter the expected queue
  task automatic drive_cycle(input logic sv, input logic [AW-1:0] sa, input logic [31:0] sd,
                             input logic lv, input logic [AW-1:0] la, input logic fr,
                             input logic accept);
    @(posedge clk);
    #1;
    st_valid  = sv;
    st_addr   = sa;
    st_data   = sd;
    st_pc     = pc_of(sa);
    ld_valid  = lv;
    ld_addr   = la;
    flush_req = fr;
    if (sv && accept) exp_q.push_back({sa, sd, pc_of(sa)});
  endtask

  task automatic idle_cycle();
    drive_cycle(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  // scoreboard: every memory write must match the oldest outstanding store
  always @(negedge clk) begin
    if (clr === 1'b1) begin
      chk("count_bound", 32'(count > 3'(DEPTH)), 32'd0);
      if (dm_memw === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'(dm_memw), 32'd0);
        end else begin
          logic [QW-1:0] e;
          e = exp_q.pop_front();
          chk("dm_add", 32'(dm_add), 32'(e[QW-1:64]));
          chk("dm_wdata", dm_wdata, e[63:32]);
          chk("dm_pc", dm_pc, e[31:0]);
        end
      end
    end
  end

  typedef struct {
    logic          sv;
    logic [AW-1:0] sa;
    logic [31:0]   sd;
    logic          lv;
    logic [AW-1:0] la;
    logic          e_rdy;
    int            e_cnt;
    logic          e_memw;
    logic          e_hit;
    logic [31:0]   e_ldata;
    logic          e_stall;
  } vec_t;

  vec_t vecs[22];

  initial begin
    logic exp_hit, exp_stall;
    logic [31:0] exp_ld;

    clr = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_pc = '0;
    ld_valid = 1'b0; ld_addr = '0; flush_req = 1'b0;

    //                sv   sa      sd            lv   la      rdy  cnt memw hit  ldata  stall
    vecs[0]  = '{1'b0, 10'h000, 32'h0,        1'b0, 10'h000, 1'b1, 0, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[1]  = '{1'b1, 10'h004, 32'h11111111, 1'b0, 10'h000, 1'b1, 0, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[2]  = '{1'b0, 10'h000, 32'h0,        1'b0, 10'h000, 1'b1, 1, 1'b1, 1'b0, 32'h0, 1'b0};
    vecs[3]  = '{1'b0, 10'h000, 32'h0,        1'b0, 10'h000, 1'b1, 0, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[4]  = '{1'b1, 10'h010, 32'h1,        1'b0, 10'h000, 1'b1, 0, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[5]  = '{1'b1, 10'h010, 32'h2,        1'b1, 10'h010, 1'b1, 1, 1'b1, 1'b1, 32'h1, 1'b1};
    vecs[6]  = '{1'b0, 10'h000, 32'h0,        1'b1, 10'h010, 1'b1, 1, 1'b1, 1'b1, 32'h2, 1'b1};
    vecs[7]  = '{1'b0, 10'h000, 32'h0,        1'b1, 10'h010, 1'b1, 0, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[8]  = '{1'b1, 10'h030, 32'h3,        1'b1, 10'h020, 1'b1, 0, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[9]  = '{1'b0, 10'h000, 32'h0,        1'b1, 10'h020, 1'b1, 1, 1'b1, 1'b0, 32'h0, 1'b1};
    // ten back-to-back pushes draining each cycle: pointers wrap twice over
    for (int i = 0; i < 10; i++)
      vecs[10+i] = '{1'b1, 10'(10'h100 + i), 32'hC0DE_0000 + 32'(i), 1'b0, 10'h000,
                     1'b1, (i == 0) ? 0 : 1, (i != 0), 1'b0, 32'h0, 1'b0};
    vecs[20] = '{1'b0, 10'h000, 32'h0,        1'b0, 10'h000, 1'b1, 1, 1'b1, 1'b0, 32'h0, 1'b0};
    vecs[21] = '{1'b0, 10'h000, 32'h0,        1'b0, 10'h000, 1'b1, 0, 1'b0, 1'b0, 32'h0, 1'b0};

    // reset values
    #3;
    chk("rst_st_ready", 32'(st_ready), 32'd1);
    chk("rst_dm_memw", 32'(dm_memw), 32'd0);
    chk("rst_ld_hit", 32'(ld_hit), 32'd0);
    chk("rst_ld_data", ld_data, 32'd0);
    chk("rst_ld_stall", 32'(ld_stall), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_flush_done", 32'(flush_done), 32'd0);
    @(negedge clk);
    #2 clr = 1'b1;

    // table vectors
    for (int i = 0; i < 22; i++) begin
      drive_cycle(vecs[i].sv, vecs[i].sa, vecs[i].sd, vecs[i].lv, vecs[i].la, 1'b0, vecs[i].e_rdy);
      @(negedge clk);
      exp_hit   = FWD ? vecs[i].e_hit   : 1'b0;
      exp_ld    = FWD ? vecs[i].e_ldata : 32'h0;
      exp_stall = FWD ? 1'b0            : vecs[i].e_stall;
      chk($sformatf("v%0d_st_ready", i), 32'(st_ready), 32'(vecs[i].e_rdy));
      chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].e_cnt));
      chk($sformatf("v%0d_empty", i), 32'(empty), 32'(vecs[i].e_cnt == 0));
      chk($sformatf("v%0d_dm_memw", i), 32'(dm_memw), 32'(vecs[i].e_memw));
      chk($sformatf("v%0d_ld_hit", i), 32'(ld_hit), 32'(exp_hit));
      chk($sformatf("v%0d_ld_data", i), ld_data, exp_ld);
      chk($sformatf("v%0d_ld_stall", i), 32'(ld_stall), 32'(exp_stall));
    end

    // flush with one pending store; a store and a repeat flush_req offered during FLUSH are ignored
    drive_cycle(1'b1, 10'h200, 32'hF1, 1'b0, '0, 1'b1, 1'b1);
    @(negedge clk);
    chk("f0_st_ready", 32'(st_ready), 32'd1);
    chk("f0_flush_done", 32'(flush_done), 32'd0);
    drive_cycle(1'b1, 10'h204, 32'hF2, 1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    chk("f1_st_ready", 32'(st_ready), 32'd0);
    chk("f1_count", 32'(count), 32'd1);
    chk("f1_flush_done", 32'(flush_done), 32'd0);
    idle_cycle();
    @(negedge clk);
    chk("f2_flush_done", 32'(flush_done), 32'd1);
    chk("f2_st_ready", 32'(st_ready), 32'd1);
    chk("f2_empty", 32'(empty), 32'd1);
    idle_cycle();
    @(negedge clk);
    chk("f3_flush_done", 32'(flush_done), 32'd0);
    chk("f3_st_ready", 32'(st_ready), 32'd1);

    // flush while already empty
    drive_cycle(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    chk("g0_st_ready", 32'(st_ready), 32'd1);
    idle_cycle();
    @(negedge clk);
    chk("g1_st_ready", 32'(st_ready), 32'd0);
    chk("g1_flush_done", 32'(flush_done), 32'd0);
    idle_cycle();
    @(negedge clk);
    chk("g2_flush_done", 32'(flush_done), 32'd1);
    chk("g2_st_ready", 32'(st_ready), 32'd1);
    idle_cycle();
    @(negedge clk);
    chk("g3_flush_done", 32'(flush_done), 32'd0);

    // reset pulsed between edges with a store pending
    drive_cycle(1'b1, 10'h300, 32'hAA, 1'b0, '0, 1'b0, 1'b1);
    drive_cycle(1'b1, 10'h304, 32'hBB, 1'b0, '0, 1'b0, 1'b1);
    @(negedge clk);
    chk("r1_count", 32'(count), 32'd1);
    idle_cycle();
    #1 clr = 1'b0;
    exp_q.delete();
    #1;
    chk("r2_count", 32'(count), 32'd0);
    chk("r2_dm_memw", 32'(dm_memw), 32'd0);
    chk("r2_empty", 32'(empty), 32'd1);
    chk("r2_dm_add", 32'(dm_add), 32'd0);
    chk("r2_st_ready", 32'(st_ready), 32'd1);
    @(negedge clk);
    #2 clr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle_cycle();
      @(negedge clk);
      chk($sformatf("r_post%0d_dm_memw", i), 32'(dm_memw), 32'd0);
      chk($sformatf("r_post%0d_count", i), 32'(count), 32'd0);
    end

    // normal operation resumes with a random store
    begin
      logic [AW-1:0] ra;
      logic [31:0]   rd;
      ra = AW'($urandom_range(0, 1023));
      rd = $urandom;
      drive_cycle(1'b1, ra, rd, 1'b0, '0, 1'b0, 1'b1);
      idle_cycle();
      @(negedge clk);
      chk("post_rst_dm_memw", 32'(dm_memw), 32'd1);
      idle_cycle();
      idle_cycle();
    end

    @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
